mvm_axis_result_rx: RTL and testbench
=====================================

MVM_AXIS_RESULT_RX -- requirements
Module: mvm_axis_result_rx

Interface
REQ-001 SHALL have parameter DATAW, default 512, payload width.
REQ-002 SHALL have parameter IDW, default 32, TID width.
REQ-003 SHALL have parameter DESTW, default 12, TDEST width.
REQ-004 SHALL have parameter USERW, default 75, TUSER width.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-006 SHALL have parameter LOCAL_DEST, default 12'h000, host endpoint address.
REQ-007 SHALL have one clock and a synchronous, active-high reset, as listed in REQ-008 and REQ-009.
REQ-008 CLK  in  1  single clock; all logic on rising edge.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 AXIS_S_TVALID/TREADY  in/out  1/1  NoC-output stream handshake.
REQ-011 AXIS_S_TDATA/TID/TDEST/TUSER/TLAST  in  DATAW/IDW/DESTW/USERW/1  NoC-output beat fields.
REQ-012 OUT_VALID/OUT_READY  out/in  1/1  host read-port handshake.
REQ-013 OUT_DATA/OUT_ID/OUT_OP/OUT_LAST  out  DATAW/IDW/2/1  head-entry fields; OUT_OP = captured TUSER[10:9].
REQ-014 PKT_CNT/DROP_CNT  out  16/16  statistics (REQ-031).

Function
REQ-015 Beat transfer SHALL occur on a rising edge with AXIS_S_TVALID and AXIS_S_TREADY both high.
REQ-016 FSM SHALL have states IDLE (awaiting first beat), KEEP (mid-packet, storing), DROP (mid-packet, discarding).
REQ-017 IDLE, first beat with TDEST == LOCAL_DEST: store beat; TLAST=1 -> IDLE, else -> KEEP.
REQ-018 IDLE, first beat with TDEST != LOCAL_DEST: discard beat; TLAST=1 -> IDLE, else -> DROP.
REQ-019 KEEP: every beat stored regardless of TDEST; TLAST=1 -> IDLE.
REQ-020 DROP: every beat discarded; TLAST=1 -> IDLE.
REQ-021 AXIS_S_TREADY SHALL be combinational: high when FIFO not full, or when current beat will be discarded (DROP state, or IDLE with TDEST mismatch).
REQ-022 Discarded beats SHALL never stall the NoC.
REQ-023 FIFO SHALL store {TDATA, TID, TUSER[10:9], TLAST}, first-in first-out, with wrap-around pointers.
REQ-024 OUT_VALID SHALL be high whenever FIFO not empty; OUT_* SHALL show head entry, stable while OUT_VALID high and OUT_READY low.
REQ-025 Latency: a beat stored at edge N SHALL show OUT_VALID high after edge N (one cycle, no bypass).
REQ-026 Pop SHALL occur on an edge with OUT_VALID and OUT_READY high.
REQ-027 Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
REQ-028 Full with a keep beat pending: TREADY low; a pop on that edge SHALL NOT enable same-cycle push (TREADY from registered occupancy).
REQ-029 Empty with OUT_READY high: no pop, no pointer change.

Reset
REQ-030 On RST: FSM -> IDLE, FIFO emptied (OUT_VALID=0), OUT_DATA/ID/OP/LAST=0, PKT_CNT=DROP_CNT=0, TREADY follows REQ-021 from empty state; reset mid-packet abandons the packet, and following beats are treated as first beats.

Configuration
REQ-031 With macro MVM_RX_STATS_EN defined: PKT_CNT SHALL increment on each stored TLAST beat, and DROP_CNT on each discarded TLAST beat; both SHALL saturate at 16'hFFFF.
REQ-032 Without MVM_RX_STATS_EN: PKT_CNT and DROP_CNT SHALL be tied to 0, and no counter registers SHALL be instantiated.

Verification
REQ-033 Single beat TDEST=LOCAL_DEST, TDATA=512'hA5, TLAST=1, OUT_READY=1 -> OUT_VALID one cycle later, OUT_DATA=512'hA5, OUT_LAST=1, PKT_CNT=1.
REQ-034 3-beat packet, first TDEST=12'h003 (mismatch), later beats TDEST=LOCAL_DEST -> TREADY high every beat, no OUT_VALID, DROP_CNT=1.
REQ-035 OUT_READY=0, 5 keep beats at DEPTH=4 -> 4 accepted, TREADY low on 5th until one pop, then 5th stored; read order 1..5.
REQ-036 FIFO full, mismatched single-beat packet -> accepted (TREADY=1), discarded, FIFO contents unchanged.
REQ-037 RST asserted after 2nd beat of a 4-beat keep packet -> OUT_VALID=0 next cycle, FSM IDLE; next beat with mismatched TDEST is dropped.
REQ-038 Build without MVM_RX_STATS_EN, repeat REQ-033 -> PKT_CNT=0, data path identical.

Source files
------------

// File: rtl/mvm_axis_result_rx_if.sv
// AXI-Stream beat bundle for the NoC-output side of the MVM result receiver.
// Ports (signals):
//   tvalid/tready         beat handshake
//   tdata/tid/tdest/tuser beat fields (widths set by DATAW/IDW/DESTW/USERW)
//   tlast                 end-of-packet marker
// Modports: master drives the beat, slave returns tready.
interface mvm_axis_result_rx_if #(
  parameter int unsigned DATAW = 512,
  parameter int unsigned IDW   = 32,
  parameter int unsigned DESTW = 12,
  parameter int unsigned USERW = 75
);
  logic             tvalid;
  logic             tready;
  logic [DATAW-1:0] tdata;
  logic [IDW-1:0]   tid;
  logic [DESTW-1:0] tdest;
  logic [USERW-1:0] tuser;
  logic             tlast;

  modport master (
    output tvalid, tdata, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/mvm_axis_result_rx.sv
// MVM result receiver: accepts NoC-output packets, keeps those whose first beat
// is addressed to LOCAL_DEST, buffers kept beats in a DEPTH-entry FIFO and
// presents them to the host read port. Packets for other endpoints are
// swallowed without ever back-pressuring the NoC.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   axis_s         NoC-output stream (slave modport)
//   out_valid/out_ready                     host read handshake
//   out_data/out_id/out_op/out_last         head entry (out_op = tuser[10:9])
//   pkt_cnt/drop_cnt                        kept / discarded packet counts
// Optional feature: define MVM_RX_STATS_EN to build the saturating packet
// counters; otherwise pkt_cnt/drop_cnt are constant zero.
module mvm_axis_result_rx #(
  parameter int unsigned      DATAW      = 512,
  parameter int unsigned      IDW        = 32,
  parameter int unsigned      DESTW      = 12,
  parameter int unsigned      USERW      = 75,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [DESTW-1:0] LOCAL_DEST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  mvm_axis_result_rx_if.slave  axis_s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAW-1:0]     out_data,
  output logic [IDW-1:0]       out_id,
  output logic [1:0]           out_op,
  output logic                 out_last,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StKeep, StDrop} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic [DATAW-1:0] mem_data [DEPTH];
  logic [IDW-1:0]   mem_id   [DEPTH];
  logic [1:0]       mem_op   [DEPTH];
  logic             mem_last [DEPTH];

  logic keep_beat, full, beat, push, pop;
  logic unused_tuser;

  assign unused_tuser = ^axis_s.tuser;

  // Only the first beat of a packet is routed on tdest; later beats follow it.
  assign keep_beat = (state_q == StKeep) ||
                     ((state_q == StIdle) && (axis_s.tdest == LOCAL_DEST));
  // Registered occupancy only: a pop on this edge does not free a slot early.
  assign full          = (count_q == DepthCnt);
  assign axis_s.tready = !keep_beat || !full;
  assign beat          = axis_s.tvalid && axis_s.tready;
  assign push          = beat && keep_beat;
  assign out_valid     = (count_q != '0);
  assign pop           = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    if (beat) begin
      unique case (state_q)
        StIdle: begin
          if (!axis_s.tlast) state_d = keep_beat ? StKeep : StDrop;
        end
        StKeep, StDrop: begin
          if (axis_s.tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= axis_s.tdata;
      mem_id[wr_ptr_q]   <= axis_s.tid;
      mem_op[wr_ptr_q]   <= axis_s.tuser[10:9];
      mem_last[wr_ptr_q] <= axis_s.tlast;
    end
  end

  always_comb begin
    out_data = '0;
    out_id   = '0;
    out_op   = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = mem_data[rd_ptr_q];
      out_id   = mem_id[rd_ptr_q];
      out_op   = mem_op[rd_ptr_q];
      out_last = mem_last[rd_ptr_q];
    end
  end

`ifdef MVM_RX_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (beat && axis_s.tlast) begin
      if (keep_beat && (pkt_cnt_q != 16'hFFFF))   pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      if (!keep_beat && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mvm_axis_result_rx.sv
module tb_mvm_axis_result_rx;

`ifdef MVM_RX_STATS_EN
  localparam int StatsOn = 1;
`else
  localparam int StatsOn = 0;
`endif

  logic         clk;
  logic         rst;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [31:0]  out_id;
  logic [1:0]   out_op;
  logic         out_last;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  int n_checks;
  int n_fail;
  int exp_pkt;
  int exp_drop;

  mvm_axis_result_rx_if #(.DATAW(512), .IDW(32), .DESTW(12), .USERW(75)) axis ();

  mvm_axis_result_rx #(
    .DATAW(512), .IDW(32), .DESTW(12), .USERW(75), .DEPTH(4), .LOCAL_DEST(12'h000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .axis_s   (axis),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_op   (out_op),
    .out_last (out_last),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_beat(input logic [11:0] dest, input logic [511:0] data,
                            input logic [31:0] id, input logic [1:0] op,
                            input logic last);
    axis.tvalid      = 1'b1;
    axis.tdest       = dest;
    axis.tdata       = data;
    axis.tid         = id;
    axis.tuser       = '0;
    axis.tuser[10:9] = op;
    axis.tlast       = last;
  endtask

  task automatic drive_idle();
    axis.tvalid = 1'b0;
    axis.tdest  = '0;
    axis.tdata  = '0;
    axis.tid    = '0;
    axis.tuser  = '0;
    axis.tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 512'h0 || out_id !== 32'h0 || out_op !== 2'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got data=%0h id=%0h op=%0d last=%b want all 0",
               out_data, out_id, out_op, out_last);
    end
    n_checks++;
    if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", pkt_cnt, drop_cnt);
    end
    n_checks++;
    if (axis.tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tready: got %b want 1", axis.tready);
    end
    rst      = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 1'b1;
    drive_beat(12'h000, 512'hA5, 32'h1234, 2'b10, 1'b1);
    #1;
    n_checks++;
    if (axis.tready !== 1'b1) begin
      n_fail++; $display("FAIL single_tready: got %b want 1", axis.tready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_no_bypass: got %b want 0", out_valid);
    end
    @(negedge clk);
    drive_idle();
    exp_pkt += StatsOn;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 512'hA5 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL single_head: got v=%b data=%0h last=%b want v=1 data=a5 last=1",
               out_valid, out_data, out_last);
    end
    n_checks++;
    if (out_id !== 32'h1234 || out_op !== 2'b10) begin
      n_fail++; $display("FAIL single_id_op: got %0h/%0d want 1234/2", out_id, out_op);
    end
    n_checks++;
    if (pkt_cnt !== 16'(exp_pkt)) begin
      n_fail++; $display("FAIL single_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_popped: got %b want 0", out_valid);
    end
  endtask

  task automatic test_drop();
    logic [11:0] dests [3];
    dests[0] = 12'h003;
    dests[1] = 12'h000;
    dests[2] = 12'h000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_beat(dests[k], 512'(k + 40), 32'(k), 2'b01, (k == 2));
      #1;
      n_checks++;
      if (axis.tready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_beat%0d: got tready=%b valid=%b want 1/0", k, axis.tready,
                 out_valid);
      end
    end
    @(negedge clk);
    drive_idle();
    exp_drop += StatsOn;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_no_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (drop_cnt !== 16'(exp_drop) || pkt_cnt !== 16'(exp_pkt)) begin
      n_fail++;
      $display("FAIL drop_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, drop_cnt, exp_pkt,
               exp_drop);
    end
  endtask

  // Continuous push+pop: occupancy holds at one, head trails input by one beat.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_beat((k == 1) ? 12'h005 : 12'h000, 512'(10 + k), 32'(k), 2'b11, (k == 3));
      #1;
      n_checks++;
      if (axis.tready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_tready%0d: got %b want 1", k, axis.tready);
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 512'(10 + k - 1)) begin
          n_fail++;
          $display("FAIL b2b_head%0d: got v=%b data=%0d want 1/%0d", k, out_valid, out_data,
                   10 + k - 1);
        end
      end
    end
    @(negedge clk);
    drive_idle();
    exp_pkt += StatsOn;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 512'd13 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_tail: got v=%b data=%0d last=%b want 1/13/1", out_valid, out_data,
               out_last);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_empty: got %b want 0", out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive_beat(12'h000, 512'(k), 32'(k + 100), 2'b00, 1'b1);
      #1;
      n_checks++;
      if (axis.tready !== 1'b1) begin
        n_fail++; $display("FAIL full_fill%0d: got tready=%b want 1", k, axis.tready);
      end
      exp_pkt += StatsOn;
    end
    // Mismatched packet while full: must still be accepted and thrown away.
    @(negedge clk);
    drive_beat(12'h003, 512'hDEAD, 32'h0, 2'b00, 1'b1);
    #1;
    n_checks++;
    if (axis.tready !== 1'b1) begin
      n_fail++; $display("FAIL full_drop_tready: got %b want 1", axis.tready);
    end
    exp_drop += StatsOn;
    @(negedge clk);
    drive_beat(12'h000, 512'd5, 32'd105, 2'b00, 1'b1);
    #1;
    n_checks++;
    if (axis.tready !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got tready=%b want 0", axis.tready);
    end
    n_checks++;
    if (out_data !== 512'd1) begin
      n_fail++; $display("FAIL full_head_kept: got %0h want 1", out_data);
    end
    @(negedge clk); #1;
    n_checks++;
    if (axis.tready !== 1'b0) begin
      n_fail++; $display("FAIL full_stall_hold: got tready=%b want 0", axis.tready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (axis.tready !== 1'b0 || out_data !== 512'd1) begin
      n_fail++;
      $display("FAIL full_pop_edge: got tready=%b head=%0d want 0/1", axis.tready, out_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (axis.tready !== 1'b1 || out_data !== 512'd2) begin
      n_fail++;
      $display("FAIL full_after_pop: got tready=%b head=%0d want 1/2", axis.tready, out_data);
    end
    exp_pkt += StatsOn;
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
    #1;
    for (int k = 2; k <= 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 512'(k) || out_id !== 32'(k + 100)) begin
        n_fail++;
        $display("FAIL full_order%0d: got v=%b data=%0d id=%0d want 1/%0d/%0d", k, out_valid,
                 out_data, out_id, k, k + 100);
      end
      @(negedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: got %b want 0", out_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 512'h0) begin
      n_fail++;
      $display("FAIL empty_ready_hold: got v=%b data=%0h want 0/0", out_valid, out_data);
    end
    n_checks++;
    if (pkt_cnt !== 16'(exp_pkt) || drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL full_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, drop_cnt, exp_pkt,
               exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_beat(12'h000, 512'(k + 60), 32'(k), 2'b01, 1'b0);
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b cnts=%0d/%0d want 0/0/0", out_valid, pkt_cnt,
               drop_cnt);
    end
    @(negedge clk);
    drive_beat(12'h003, 512'h99, 32'h9, 2'b01, 1'b1);
    #1;
    n_checks++;
    if (axis.tready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_tready: got %b want 1", axis.tready);
    end
    exp_drop += StatsOn;
    @(negedge clk);
    drive_beat(12'h000, 512'h77, 32'h7, 2'b11, 1'b1);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_dropped: got v=%b want 0", out_valid);
    end
    exp_pkt += StatsOn;
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 512'h77 || out_op !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_keep: got v=%b data=%0h op=%0d want 1/77/3", out_valid, out_data,
               out_op);
    end
    n_checks++;
    if (pkt_cnt !== 16'(exp_pkt) || drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL midrst_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, drop_cnt, exp_pkt,
               exp_drop);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_popped: got %b want 0", out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_pkt  = 0;
    exp_drop = 0;
    test_reset();
    test_single();
    test_drop();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
